scale_ctrl: RTL and testbench

SCALE_CTRL -- requirements
Module: scale_ctrl

---
 rtl/scale_pkg.sv | 22 ++
 rtl/skid_fifo.sv | 50 +++++
 rtl/scale_ctrl.sv | 140 ++++++++++++++
 tb/tb_scale_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_pkg.sv
// Shared types and default widths for the requantisation scale controller.
package scale_pkg;

  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_M0_WIDTH   = 32;
  localparam int DEF_N_CH       = 16;
  localparam int DEF_ROW_W      = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int Q_WIDTH        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } scale_state_e;

  // Index width that stays legal for a single-entry table.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skid_fifo.sv
// Small circular FIFO holding {q, last} results until the int8 sink takes them.
module skid_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    rdata_o = mem_q[rd_q];
    count_o = count_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
      end
      if (do_pop) rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/scale_ctrl.sv
// Feeds psums with their per-channel scale to an external 1-cycle datapath and
// buffers the int8 results for a backpressured downstream stream.
module scale_ctrl
  import scale_pkg::*;
#(
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int M0_WIDTH   = DEF_M0_WIDTH,
  parameter int N_CH       = DEF_N_CH,
  parameter int ROW_W      = DEF_ROW_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        cfg_we_i,
  input  logic [addr_w(N_CH)-1:0]     cfg_addr_i,
  input  logic [M0_WIDTH-1:0]         cfg_m0_i,
  input  logic                        start_i,
  input  logic [ROW_W-1:0]            rows_i,
  output logic                        busy_o,
  output logic                        done_o,
  input  logic                        psum_valid_i,
  output logic                        psum_ready_o,
  input  logic [ACC_WIDTH-1:0]        psum_i,
  output logic [M0_WIDTH-1:0]         scale_o,
  output logic                        scale_valid_o,
  output logic [ACC_WIDTH-1:0]        sdata_o,
  output logic                        sdata_valid_o,
  input  logic                        q_valid_i,
  input  logic signed [Q_WIDTH-1:0]   q_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [Q_WIDTH-1:0]          out_data_o,
  output logic                        out_last_o,
  output scale_state_e                state_o
);

  localparam int AW  = addr_w(N_CH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CW1 = CW + 1;

  scale_state_e        state_q, state_d;
  logic [M0_WIDTH-1:0] scale_tab_q [N_CH];
  logic [AW-1:0]       ch_q;
  logic [ROW_W-1:0]    row_q, rows_q;
  logic                inflight_q, inflight_last_q, zero_done_q;
  logic [CW-1:0]       fifo_count;
  logic [Q_WIDTH:0]    fifo_head;
  logic                start_job, start_zero, accept, beat_last;
  logic                push, pop, drain_done;

  // Both streams transfer on a cycle where valid && ready; a source keeps its
  // beat stable until that cycle. Upstream credit counts the beat still in the
  // datapath so a full FIFO can always absorb it.
  always_comb begin
    start_job     = (state_q == ST_IDLE) && start_i && (rows_i != '0);
    start_zero    = (state_q == ST_IDLE) && start_i && (rows_i == '0);
    psum_ready_o  = (state_q == ST_RUN) &&
                    (({1'b0, fifo_count} + {{CW{1'b0}}, inflight_q}) < CW1'(FIFO_DEPTH));
    accept        = psum_valid_i && psum_ready_o;
    beat_last     = (row_q == rows_q - ROW_W'(1)) && (ch_q == AW'(N_CH - 1));
    sdata_valid_o = accept;
    scale_valid_o = accept;
    sdata_o       = accept ? psum_i : '0;
    scale_o       = accept ? scale_tab_q[ch_q] : '0;
    push          = q_valid_i && inflight_q;
    out_valid_o   = (fifo_count != '0);
    out_data_o    = out_valid_o ? fifo_head[Q_WIDTH:1] : '0;
    out_last_o    = out_valid_o && fifo_head[0];
    pop           = out_valid_o && out_ready_i;
    drain_done    = (state_q == ST_DRAIN) && pop && fifo_head[0];
    done_o        = zero_done_q || drain_done;
    busy_o        = (state_q != ST_IDLE);
    state_o       = state_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_job) state_d = ST_RUN;
      ST_RUN:   if (accept && beat_last) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ch_q            <= '0;
      row_q           <= '0;
      rows_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      zero_done_q     <= 1'b0;
    end else begin
      zero_done_q     <= start_zero;
      inflight_q      <= accept;
      inflight_last_q <= accept && beat_last;
      if (start_job) begin
        rows_q <= rows_i;
        ch_q   <= '0;
        row_q  <= '0;
      end else if (accept) begin
        if (ch_q == AW'(N_CH - 1)) begin
          ch_q  <= '0;
          row_q <= row_q + ROW_W'(1);
        end else begin
          ch_q  <= ch_q + AW'(1);
        end
      end
    end
  end

  // Scale table is only writable between jobs so a running job sees one set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_CH; i++) scale_tab_q[i] <= '0;
    end else if (cfg_we_i && (state_q == ST_IDLE)) begin
      scale_tab_q[cfg_addr_i] <= cfg_m0_i;
    end
  end

  skid_fifo #(
    .WIDTH (Q_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i ({q_i, inflight_last_q}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_scale_ctrl.sv
// Directed bench for scale_ctrl: job-level model, emulated 1-cycle scale datapath.
module tb_scale_ctrl;
  import scale_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               cfg_we_i;
  logic [3:0]         cfg_addr_i;
  logic [31:0]        cfg_m0_i;
  logic               start_i;
  logic [15:0]        rows_i;
  logic               busy_o, done_o;
  logic               psum_valid_i, psum_ready_o;
  logic [31:0]        psum_i;
  logic [31:0]        scale_o, sdata_o;
  logic               scale_valid_o, sdata_valid_o;
  logic               q_valid_i;
  logic signed [7:0]  q_i;
  logic               out_valid_o, out_ready_i, out_last_o;
  logic [7:0]         out_data_o;
  scale_state_e       state_o;

  int total = 0;
  int bad   = 0;

  // model state
  bit          m_busy, m_run, m_zero_done, acc_prev;
  int          m_rows, m_acc, m_out, m_vis;
  logic [31:0] m_tab [16];
  logic [8:0]  exp_q [$];
  // emulated datapath and stray-strobe injection
  logic        dp_v, stray_q;
  logic [7:0]  dp_q;
  // per-test observations for literal checks
  int          n_pop, n_last, last_idx, n_done, n_sdv, n_s99, n_rdy_low, max_out, n_busy;
  logic [7:0]  first_data, last_data;

  scale_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_m0_i(cfg_m0_i),
    .start_i(start_i), .rows_i(rows_i), .busy_o(busy_o), .done_o(done_o),
    .psum_valid_i(psum_valid_i), .psum_ready_o(psum_ready_o), .psum_i(psum_i),
    .scale_o(scale_o), .scale_valid_o(scale_valid_o),
    .sdata_o(sdata_o), .sdata_valid_o(sdata_valid_o),
    .q_valid_i(q_valid_i), .q_i(q_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o),
    .state_o(state_o)
  );

  // clock / reset
  initial forever #5 clk_i = ~clk_i;

  function automatic void chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  // datapath emulator: result one cycle after the request
  initial begin
    q_valid_i = 1'b0;
    q_i       = '0;
    forever begin
      @(posedge clk_i);
      #1;
      q_valid_i = dp_v;
      q_i       = dp_q;
    end
  end

  // compare process
  always @(negedge clk_i) begin
    logic       exp_ready, acc, mpop, exp_done, lastb;
    logic [8:0] ent;
    logic [7:0] qx;
    if (!rst_ni) begin
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_psum_ready", psum_ready_o, 0);
      chk("rst_out_last", out_last_o, 0);
      chk("rst_out_data", out_data_o, 0);
      chk("rst_sdata_valid", sdata_valid_o, 0);
      chk("rst_scale_valid", scale_valid_o, 0);
      chk("rst_state", state_o, ST_IDLE);
      m_busy = 0; m_run = 0; m_zero_done = 0; acc_prev = 0;
      m_rows = 0; m_acc = 0; m_out = 0; m_vis = 0;
      for (int i = 0; i < 16; i++) m_tab[i] = '0;
      exp_q.delete();
      dp_v = 1'b0;
      dp_q = '0;
    end else begin
      exp_ready = m_run && (m_out < 4);
      acc       = psum_valid_i && exp_ready;
      chk("psum_ready", psum_ready_o, exp_ready);
      chk("sdata_valid", sdata_valid_o, acc);
      chk("scale_valid", scale_valid_o, acc);
      chk("scale", scale_o, acc ? m_tab[m_acc % 16] : 32'd0);
      chk("sdata", sdata_o, acc ? psum_i : 32'd0);
      chk("busy", busy_o, m_busy);
      chk("out_valid", out_valid_o, m_vis != 0);
      mpop     = (m_vis != 0) && out_ready_i;
      exp_done = m_zero_done;
      ent      = '0;
      if (mpop) begin
        if (exp_q.size() == 0) chk("pop_underflow", 1, 0);
        else begin
          ent = exp_q.pop_front();
          chk("out_data", out_data_o, ent[8:1]);
          chk("out_last", out_last_o, ent[0]);
          n_pop++;
          if (n_pop == 1) first_data = out_data_o;
          last_data = out_data_o;
          if (ent[0]) begin
            exp_done = 1'b1;
            n_last++;
            last_idx = n_pop;
          end
        end
      end
      chk("done", done_o, exp_done);
      if (done_o) n_done++;
      if (sdata_valid_o) n_sdv++;
      if (scale_valid_o && scale_o == 32'd99) n_s99++;
      if (m_run && !psum_ready_o) n_rdy_low++;
      if (busy_o) n_busy++;
      // advance the model to the next cycle
      m_zero_done = 0;
      if (!m_busy && start_i) begin
        if (rows_i != 0) begin
          m_busy = 1; m_run = 1; m_rows = int'(rows_i); m_acc = 0;
        end else m_zero_done = 1;
      end
      if (!m_busy && cfg_we_i) m_tab[cfg_addr_i] = cfg_m0_i;
      if (acc) begin
        qx    = 8'(psum_i + m_tab[m_acc % 16] * 32'd3);
        lastb = (m_acc == m_rows * 16 - 1);
        exp_q.push_back({qx, lastb});
        m_acc++;
        if (lastb) m_run = 0;
      end
      if (mpop && ent[0]) m_busy = 0;
      m_out = m_out + int'(acc) - int'(mpop);
      m_vis = m_vis - int'(mpop) + int'(acc_prev);
      acc_prev = acc;
      if (m_out > max_out) max_out = m_out;
      dp_v = sdata_valid_o | stray_q;
      dp_q = 8'(sdata_o + scale_o * 32'd3);
    end
  end

  // driver tasks (called at posedge+1)
  task automatic write_cfg(input int addr, input int val);
    cfg_we_i = 1'b1; cfg_addr_i = 4'(addr); cfg_m0_i = 32'(val);
    @(posedge clk_i); #1;
    cfg_we_i = 1'b0;
  endtask

  task automatic start_job(input int rows);
    start_i = 1'b1; rows_i = 16'(rows);
    @(posedge clk_i); #1;
    start_i = 1'b0; rows_i = '0;
  endtask

  task automatic send_beats(input int n, input int base, input int rst_at);
    int k, g;
    k = 0; g = 0;
    while (k < n && g < 2000) begin
      if (k == rst_at) begin
        rst_ni = 1'b0;
        break;
      end
      psum_valid_i = 1'b1;
      psum_i       = 32'(base + k * 5);
      @(negedge clk_i);
      if (psum_ready_o) k++;
      @(posedge clk_i); #1;
      g++;
    end
    psum_valid_i = 1'b0;
    if (rst_at < 0) chk("beats_sent", k, n);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk_i);
    while (busy_o && g < 500) begin
      @(negedge clk_i);
      g++;
    end
    chk("idle_timeout", busy_o, 0);
    @(posedge clk_i); #1;
  endtask

  task automatic clear_obs();
    n_pop = 0; n_last = 0; last_idx = 0; n_done = 0; n_sdv = 0;
    n_s99 = 0; n_rdy_low = 0; max_out = 0; n_busy = 0;
    first_data = '0; last_data = '0;
  endtask

  initial begin
    rst_ni = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_m0_i = '0;
    start_i = 1'b0; rows_i = '0; psum_valid_i = 1'b0; psum_i = '0;
    out_ready_i = 1'b1; stray_q = 1'b0;
    clear_obs();
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // full job, table k+1, two rows back to back
    for (int k = 0; k < 16; k++) write_cfg(k, k + 1);
    clear_obs();
    start_job(2);
    send_beats(32, 7, -1);
    wait_idle();
    chk("t1_pops", n_pop, 32);
    chk("t1_lasts", n_last, 1);
    chk("t1_last_idx", last_idx, 32);
    chk("t1_dones", n_done, 1);
    chk("t1_first_q", first_data, 10);
    chk("t1_last_q", last_data, 210);

    // downstream stall for 10 cycles mid-job
    clear_obs();
    start_job(2);
    fork
      send_beats(32, 100, -1);
      begin
        repeat (8) @(posedge clk_i);
        #1 out_ready_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1 out_ready_i = 1'b1;
      end
    join
    wait_idle();
    chk("t2_pops", n_pop, 32);
    chk("t2_max_outstanding", max_out, 4);
    chk("t2_ready_dropped", n_rdy_low > 0, 1);

    // zero-row start, plus a stray datapath strobe while idle
    clear_obs();
    stray_q = 1'b1;
    @(posedge clk_i); #1;
    stray_q = 1'b0;
    start_job(0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("t3_dones", n_done, 1);
    chk("t3_sdata_valid", n_sdv, 0);
    chk("t3_busy", n_busy, 0);
    chk("t3_pops", n_pop, 0);

    // table write attempted during RUN
    clear_obs();
    start_job(1);
    fork
      send_beats(16, 3, -1);
      begin
        cfg_we_i = 1'b1; cfg_addr_i = 4'd3; cfg_m0_i = 32'd99;
        repeat (6) @(posedge clk_i);
        #1 cfg_we_i = 1'b0;
      end
    join
    wait_idle();
    chk("t4_scale99", n_s99, 0);
    chk("t4_pops", n_pop, 16);

    // start pulsed during RUN
    clear_obs();
    start_job(1);
    fork
      send_beats(16, 11, -1);
      begin
        repeat (3) @(posedge clk_i);
        #1 start_i = 1'b1; rows_i = 16'd5;
        @(posedge clk_i);
        #1 start_i = 1'b0; rows_i = '0;
      end
    join
    wait_idle();
    chk("t5_pops", n_pop, 16);
    chk("t5_dones", n_done, 1);

    // reset at beat 7, then a fresh full job with a new table
    clear_obs();
    start_job(2);
    send_beats(32, 20, 7);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int k = 0; k < 16; k++) write_cfg(k, 2 * k + 1);
    clear_obs();
    start_job(2);
    send_beats(32, 9, -1);
    wait_idle();
    chk("t6_pops", n_pop, 32);
    chk("t6_lasts", n_last, 1);
    chk("t6_first_q", first_data, 12);
    chk("t6_last_q", last_data, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
